shift_rotate_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter/rotator; successor to the 16-bit combinational shifter.

---
 rtl/shift_rotate_pipe.sv | 144 ++++++++++++++
 tb/tb_shift_rotate_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_pipe.sv
// shift_rotate_pipe
//   Pipelined barrel shifter / rotator with a valid/ready streaming interface.
//   Each of the SHW stages shifts by a fixed power of two (stage k by 2^k)
//   when the matching shift-amount bit is set. The last stage is the output
//   register, so a result appears SHW cycles after it is accepted.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready drops only while the output stalls
//   in_data, in_shift     operand and shift amount (0..WIDTH-1)
//   in_lr                 0 = right, 1 = left
//   in_mode               00 logical, 01 arithmetic, 10 rotate, 11 reserved (error)
//   out_valid / out_ready output handshake
//   out_data, out_zero    result and result == 0 flag
//   out_err               result came from a reserved-mode operation
//   busy                  any stage, including the output register, holds an operation
module shift_rotate_pipe #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_lr,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err,
  output logic             busy
);

  // One pipeline step: shift/rotate d by amt when en is set, otherwise pass.
  // The arithmetic fill uses the sign captured at acceptance, never a bit of
  // the partially shifted data.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic             en,
    input logic             lr,
    input logic [1:0]       mode,
    input logic             sign,
    input int               amt
  );
    logic [WIDTH-1:0] hi_mask;
    logic [WIDTH-1:0] r;
    hi_mask = ~({WIDTH{1'b1}} >> amt);
    r = d;
    if (en) begin
      case (mode)
        2'b00:   r = lr ? (d << amt) : (d >> amt);
        2'b01:   r = lr ? (d << amt) : ((d >> amt) | (sign ? hi_mask : {WIDTH{1'b0}}));
        2'b10:   r = lr ? ((d << amt) | (d >> (WIDTH - amt)))
                        : ((d >> amt) | (d << (WIDTH - amt)));
        default: r = d;  // reserved mode: operand was already forced to zero
      endcase
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Data, error and valid travel through every stage including the output register.
  logic [WIDTH-1:0] data_r [SHW];
  logic [SHW-1:0]   err_r;
  logic [SHW-1:0]   valid_r;
  logic             zero_r;

  // Sideband needed only by the stages after each register; the remaining
  // shift amount is kept right-aligned so the next stage always uses bit 0.
  logic [SHW-1:0]   shift_r [SHW-1];
  logic [1:0]       mode_r  [SHW-1];
  logic [SHW-2:0]   lr_r;
  logic [SHW-2:0]   sign_r;

  logic [WIDTH-1:0] next_data_s [SHW];
  logic [WIDTH-1:0] entry_data_s;
  logic             stall_s;
  logic             accept_s;

  assign stall_s  = valid_r[SHW-1] & ~out_ready;
  assign accept_s = in_valid & ~stall_s;
  assign in_ready = ~stall_s;

  // Next-state data for every stage.
  always_comb begin
    entry_data_s   = (in_mode == 2'b11) ? {WIDTH{1'b0}} : in_data;
    next_data_s[0] = shift_step(entry_data_s, in_shift[0], in_lr, in_mode,
                                in_data[WIDTH-1], 1);
    for (int k = 1; k < SHW; k++) begin
      next_data_s[k] = shift_step(data_r[k-1], shift_r[k-1][0], lr_r[k-1],
                                  mode_r[k-1], sign_r[k-1], 1 << k);
    end
  end

  // Pipeline registers: all stages advance together unless the output stalls;
  // bubbles advance like operations so nothing is compacted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
      for (int k = 0; k < SHW - 1; k++) begin
        shift_r[k] <= {SHW{1'b0}};
        mode_r[k]  <= 2'b00;
      end
      lr_r    <= {(SHW-1){1'b0}};
      sign_r  <= {(SHW-1){1'b0}};
      err_r   <= {SHW{1'b0}};
      valid_r <= {SHW{1'b0}};
      zero_r  <= 1'b1;
    end else if (!stall_s) begin
      data_r[0]  <= next_data_s[0];
      err_r[0]   <= accept_s & (in_mode == 2'b11);
      valid_r[0] <= accept_s;
      shift_r[0] <= in_shift >> 1;
      mode_r[0]  <= in_mode;
      lr_r[0]    <= in_lr;
      sign_r[0]  <= in_data[WIDTH-1];
      for (int k = 1; k < SHW; k++) begin
        data_r[k]  <= next_data_s[k];
        err_r[k]   <= err_r[k-1];
        valid_r[k] <= valid_r[k-1];
      end
      for (int k = 1; k < SHW - 1; k++) begin
        shift_r[k] <= shift_r[k-1] >> 1;
        mode_r[k]  <= mode_r[k-1];
        lr_r[k]    <= lr_r[k-1];
        sign_r[k]  <= sign_r[k-1];
      end
      zero_r <= (next_data_s[SHW-1] == {WIDTH{1'b0}});
    end
  end

  assign out_data  = data_r[SHW-1];
  assign out_valid = valid_r[SHW-1];
  assign out_err   = err_r[SHW-1];
  assign out_zero  = zero_r;
  assign busy      = |valid_r;

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Bench for shift_rotate_pipe (WIDTH = 16): directed cases with literal
// expectations, a back-to-back stream, a stall window, a mid-flight reset and a
// randomized run, all checked against a queue-based reference model.
module tb_shift_rotate_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [3:0]  in_shift = 4'd0;
  logic        in_lr = 1'b0;
  logic [1:0]  in_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_err;
  logic        busy;

  shift_rotate_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_lr(in_lr), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;
  int stall_cnt  = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [15:0] d;
    logic        err;
    int          acc;
    int          stl;
    bit          seen;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: rotations via a doubled word, arithmetic via signed shift.
  function automatic logic [15:0] ref_op(input logic [15:0] d, input int n,
                                         input logic lr, input logic [1:0] m);
    logic [31:0]        dd;
    logic signed [15:0] sd;
    int                 r;
    case (m)
      2'b00: return lr ? (d << n) : (d >> n);
      2'b01: begin
        sd = d;
        if (lr) return d << n;
        else    return sd >>> n;
      end
      2'b10: begin
        r  = lr ? ((16 - n) % 16) : n;
        dd = {d, d} >> r;
        return dd[15:0];
      end
      default: return 16'h0000;
    endcase
  endfunction

  // Scoreboard / compare process, evaluated away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    cyc++;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 16'h0000);
      chk("rst_out_zero", out_zero, 1);
      chk("rst_out_err", out_err, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      chk("busy", busy, q.size() != 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
        end else begin
          chk("out_data", out_data, q[0].d);
          chk("out_zero", out_zero, q[0].d == 16'h0000);
          chk("out_err", out_err, q[0].err);
          if (!q[0].seen) begin
            chk("latency", cyc - q[0].acc - (stall_cnt - q[0].stl), 4);
            q[0].seen = 1'b1;
          end
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0) begin
        lat = cyc - q[0].acc - (stall_cnt - q[0].stl);
        if (lat > 4) begin
          chk("missing_output", out_valid, 1);
          void'(q.pop_front());
        end
      end
      if (out_valid && !out_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        e.d    = ref_op(in_data, int'(in_shift), in_lr, in_mode);
        e.err  = (in_mode == 2'b11);
        e.acc  = cyc;
        e.stl  = stall_cnt;
        e.seen = 1'b0;
        q.push_back(e);
      end
    end
  end

  // Random downstream backpressure during the randomized phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Caller is aligned at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [15:0] d, input logic [3:0] s,
                      input logic lr, input logic [1:0] m);
    int n;
    in_data = d; in_shift = s; in_lr = lr; in_mode = m; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      k++;
      @(negedge clk);
    end
    chk("idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Single operation on an empty pipeline with a hand-computed result.
  task automatic run_one(input string name, input logic [15:0] d, input logic [3:0] s,
                         input logic lr, input logic [1:0] m,
                         input logic [15:0] exp_d, input logic exp_err);
    int k;
    out_ready = 1'b1;
    wait_idle();
    chk({"model_", name}, ref_op(d, int'(s), lr, m), exp_d);
    send(d, s, lr, m);
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk({name, "_latency"}, k, 4);
    chk({name, "_data"}, out_data, exp_d);
    chk({name, "_zero"}, out_zero, exp_d == 16'h0000);
    chk({name, "_err"}, out_err, exp_err);
  endtask

  task automatic stream_test();
    int  run;
    int  k;
    bit  started;
    bit  done;
    run = 0; k = 0; started = 1'b0; done = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    fork
      begin
        for (int i = 0; i < 16; i++) send(16'hff00, 4'(i), 1'b0, 2'b00);
      end
      begin
        while (!done && k < 80) begin
          @(negedge clk);
          k++;
          if (out_valid) begin
            started = 1'b1;
            run++;
          end else if (started) begin
            done = 1'b1;
          end
        end
      end
    join
    chk("stream_run", run, 16);
  endtask

  task automatic stall_test();
    int          n;
    logic [15:0] held;
    n = 0;
    out_ready = 1'b1;
    wait_idle();
    fork
      begin
        for (int i = 0; i < 12; i++) send(16'h8421 ^ 16'(i * 16'h1111), 4'(i + 1), i[0], 2'(i % 3));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        if (!in_ready) n++;
        repeat (5) begin
          @(negedge clk);
          if (!in_ready) n++;
          chk("stall_hold", out_data, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    chk("stall_in_ready_low", n, 6);
  endtask

  task automatic reset_test();
    out_ready = 1'b1;
    wait_idle();
    send(16'h1111, 4'd1, 1'b1, 2'b00);
    send(16'h2222, 4'd2, 1'b0, 2'b10);
    send(16'h3333, 4'd3, 1'b0, 2'b01);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    run_one("rst_1234", 16'h1234, 4'd4, 1'b1, 2'b00, 16'h2340, 1'b0);
  endtask

  task automatic random_test();
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)));
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    run_one("lsr3",      16'hff00, 4'd3,  1'b0, 2'b00, 16'h1fe0, 1'b0);
    run_one("asr3",      16'hff00, 4'd3,  1'b0, 2'b01, 16'hffe0, 1'b0);
    run_one("asl3",      16'h00ff, 4'd3,  1'b1, 2'b01, 16'h07f8, 1'b0);
    run_one("ror4",      16'h00ff, 4'd4,  1'b0, 2'b10, 16'hf00f, 1'b0);
    run_one("rol12",     16'h00ff, 4'd12, 1'b1, 2'b10, 16'hf00f, 1'b0);
    run_one("rol1",      16'h8001, 4'd1,  1'b1, 2'b10, 16'h0003, 1'b0);
    run_one("shift0",    16'hbeef, 4'd0,  1'b0, 2'b01, 16'hbeef, 1'b0);
    run_one("asr15",     16'h8000, 4'd15, 1'b0, 2'b01, 16'hffff, 1'b0);
    run_one("mode11",    16'ha5c3, 4'd5,  1'b0, 2'b11, 16'h0000, 1'b1);
    run_one("after_err", 16'h0f0f, 4'd8,  1'b1, 2'b00, 16'h0f00, 1'b0);
    run_one("zero_res",  16'h0001, 4'd1,  1'b0, 2'b00, 16'h0000, 1'b0);

    stream_test();
    stall_test();
    reset_test();
    random_test();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
